vertex_scheduler: RTL and testbench

- Sequences the MVP transform unit (mvp_matrix) for one frame.
- On frame_start it optionally rebuilds the MVP matrix from the latched camera pose (update pass). It then walks the vertex memory from index 0 to num_vertices-1, issuing one transform per vertex.
- Each projected integer result is emitted on a valid/ready stream toward the rasterizer.
- Sits between the flight-state/vertex memories and the rasterizer front end.

---
 rtl/vertex_scheduler.sv | 171 +++++++++++++++++
 tb/tb_vertex_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_scheduler.sv
// Frame sequencer for the MVP transform unit: runs an optional pose update pass,
// then one transform per vertex, and streams each result out over valid/ready.
module vertex_scheduler #(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              update_pose,
    input  logic [31:0]       roll,
    input  logic [31:0]       pitch,
    input  logic [31:0]       yaw,
    input  logic [31:0]       cam_x,
    input  logic [31:0]       cam_y,
    input  logic [31:0]       cam_z,
    input  logic [ADDR_W:0]   num_vertices,
    output logic [ADDR_W-1:0] vtx_addr,
    input  logic [31:0]       vtx_x,
    input  logic [31:0]       vtx_y,
    input  logic [31:0]       vtx_z,
    output logic              mvp_start,
    output logic              mvp_update,
    output logic [31:0]       mvp_roll,
    output logic [31:0]       mvp_pitch,
    output logic [31:0]       mvp_yaw,
    output logic [31:0]       mvp_x,
    output logic [31:0]       mvp_y,
    output logic [31:0]       mvp_z,
    input  logic              mvp_done,
    input  logic [31:0]       mvp_ox,
    input  logic [31:0]       mvp_oy,
    input  logic [31:0]       mvp_oz,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_x,
    output logic [31:0]       out_y,
    output logic [31:0]       out_z,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    typedef enum logic [3:0] {
        IDLE, UPD_START, UPD_GUARD, UPD_WAIT, FETCH, LOAD,
        XF_START, XF_GUARD, XF_WAIT, EMIT, DONE
    } state_t;

    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state;
    logic [31:0]     cam_x_q, cam_y_q, cam_z_q;
    logic [31:0]     vert_x_q, vert_y_q, vert_z_q;
    logic [ADDR_W:0] count_q, index_q;
    logic [ADDR_W:0] count_clamped;
    logic            upd_phase, is_last;

    assign count_clamped = (num_vertices > MAX_COUNT) ? MAX_COUNT : num_vertices;
    // Full-width compare so a 2^ADDR_W frame reaches its last vertex without the index wrapping.
    assign is_last       = (index_q == count_q - ONE);
    assign upd_phase     = (state == UPD_START) || (state == UPD_GUARD) || (state == UPD_WAIT);

    // Start is gated by mvp_done so a request can never reach a busy transform unit.
    assign mvp_start  = ((state == UPD_START) || (state == XF_START)) && mvp_done;
    assign mvp_update = (state == UPD_START) && mvp_done;
    assign mvp_x      = upd_phase ? cam_x_q : vert_x_q;
    assign mvp_y      = upd_phase ? cam_y_q : vert_y_q;
    assign mvp_z      = upd_phase ? cam_z_q : vert_z_q;
    assign vtx_addr   = index_q[ADDR_W-1:0];
    assign busy       = (state != IDLE);
    assign overrun    = frame_start && (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            mvp_roll   <= '0;
            mvp_pitch  <= '0;
            mvp_yaw    <= '0;
            cam_x_q    <= '0;
            cam_y_q    <= '0;
            cam_z_q    <= '0;
            vert_x_q   <= '0;
            vert_y_q   <= '0;
            vert_z_q   <= '0;
            count_q    <= '0;
            index_q    <= '0;
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            out_z      <= '0;
            out_index  <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        mvp_roll  <= roll;
                        mvp_pitch <= pitch;
                        mvp_yaw   <= yaw;
                        cam_x_q   <= cam_x;
                        cam_y_q   <= cam_y;
                        cam_z_q   <= cam_z;
                        count_q   <= count_clamped;
                        index_q   <= '0;
                        if (update_pose) begin
                            state <= UPD_START;
                        end else if (count_clamped == '0) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                UPD_START: if (mvp_done) state <= UPD_GUARD;
                UPD_GUARD: state <= UPD_WAIT;
                UPD_WAIT: begin
                    if (mvp_done) begin
                        if (count_q == '0) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    vert_x_q <= vtx_x;
                    vert_y_q <= vtx_y;
                    vert_z_q <= vtx_z;
                    state    <= XF_START;
                end
                XF_START: if (mvp_done) state <= XF_GUARD;
                XF_GUARD: state <= XF_WAIT;
                XF_WAIT: begin
                    if (mvp_done) begin
                        out_x     <= mvp_ox;
                        out_y     <= mvp_oy;
                        out_z     <= mvp_oz;
                        out_index <= index_q[ADDR_W-1:0];
                        out_last  <= is_last;
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            index_q <= index_q + ONE;
                            state   <= FETCH;
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vertex_scheduler.sv
// Directed bench for vertex_scheduler with a behavioural mvp_matrix stand-in
// (fixed latency, result = operand + per-axis offset) and a registered vertex memory.
module tb_vertex_scheduler;

    localparam int ADDR_W  = 4;
    localparam int MVP_LAT = 4;
    localparam logic [31:0] ROLL_A  = 32'h1111_1111;
    localparam logic [31:0] PITCH_A = 32'h2222_2222;
    localparam logic [31:0] YAW_A   = 32'h3333_3333;
    localparam logic [31:0] CAM_X_A = 32'h4444_4444;
    localparam logic [31:0] CAM_Y_A = 32'h5555_5555;
    localparam logic [31:0] CAM_Z_A = 32'h6666_6666;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              frame_start = 1'b0, update_pose = 1'b0;
    logic [31:0]       roll = ROLL_A, pitch = PITCH_A, yaw = YAW_A;
    logic [31:0]       cam_x = CAM_X_A, cam_y = CAM_Y_A, cam_z = CAM_Z_A;
    logic [ADDR_W:0]   num_vertices = '0;
    logic [ADDR_W-1:0] vtx_addr;
    logic [31:0]       vtx_x = '0, vtx_y = '0, vtx_z = '0;
    logic              mvp_start, mvp_update;
    logic [31:0]       mvp_roll, mvp_pitch, mvp_yaw, mvp_x, mvp_y, mvp_z;
    logic              mvp_done;
    logic [31:0]       mvp_ox, mvp_oy, mvp_oz;
    logic              out_valid, out_ready = 1'b1;
    logic [31:0]       out_x, out_y, out_z;
    logic [ADDR_W-1:0] out_index;
    logic              out_last, busy, frame_done, overrun;

    vertex_scheduler #(.ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .frame_start(frame_start), .update_pose(update_pose),
        .roll(roll), .pitch(pitch), .yaw(yaw), .cam_x(cam_x), .cam_y(cam_y), .cam_z(cam_z),
        .num_vertices(num_vertices), .vtx_addr(vtx_addr),
        .vtx_x(vtx_x), .vtx_y(vtx_y), .vtx_z(vtx_z),
        .mvp_start(mvp_start), .mvp_update(mvp_update),
        .mvp_roll(mvp_roll), .mvp_pitch(mvp_pitch), .mvp_yaw(mvp_yaw),
        .mvp_x(mvp_x), .mvp_y(mvp_y), .mvp_z(mvp_z), .mvp_done(mvp_done),
        .mvp_ox(mvp_ox), .mvp_oy(mvp_oy), .mvp_oz(mvp_oz),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z),
        .out_index(out_index), .out_last(out_last),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clock = ~clock;

    // Vertex memory with one cycle of read latency.
    logic [31:0] mem_x [16], mem_y [16], mem_z [16];
    always @(posedge clock) begin
        vtx_x <= mem_x[vtx_addr];
        vtx_y <= mem_y[vtx_addr];
        vtx_z <= mem_z[vtx_addr];
    end

    // Transform unit stand-in; hold_done lets the bench stretch its busy time.
    logic        model_done, hold_done = 1'b0;
    int          lat_cnt;
    logic [31:0] cap_x, cap_y, cap_z;
    int          operand_viol = 0;
    assign mvp_done = model_done & ~hold_done;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            model_done <= 1'b1;
            lat_cnt    <= 0;
            cap_x <= '0; cap_y <= '0; cap_z <= '0;
            mvp_ox <= '0; mvp_oy <= '0; mvp_oz <= '0;
        end else if (mvp_start) begin
            model_done <= 1'b0;
            lat_cnt    <= MVP_LAT;
            cap_x <= mvp_x; cap_y <= mvp_y; cap_z <= mvp_z;
        end else if (!model_done) begin
            if (lat_cnt == 1) begin
                model_done <= 1'b1;
                mvp_ox <= cap_x + 32'd1000;
                mvp_oy <= cap_y + 32'd2000;
                mvp_oz <= cap_z + 32'd3000;
            end
            lat_cnt <= lat_cnt - 1;
            if (mvp_x !== cap_x || mvp_y !== cap_y || mvp_z !== cap_z)
                operand_viol <= operand_viol + 1;
        end
    end

    // Event log of everything the directed steps inspect afterwards.
    int                cyc = 0;
    int                fs_cyc_q[$], start_cyc_q[$], hs_cyc_q[$], done_cyc_q[$];
    logic              start_upd_q[$], hs_last_q[$];
    logic [31:0]       start_x_q[$], start_y_q[$], start_z_q[$], hs_x_q[$], hs_y_q[$], hs_z_q[$];
    logic [ADDR_W-1:0] hs_idx_q[$];
    int                ovr_cnt = 0, valid_cycles = 0, start_viol = 0;

    always @(posedge clock) begin
        if (reset && frame_start && !busy) fs_cyc_q.push_back(cyc);
        if (mvp_start) begin
            start_cyc_q.push_back(cyc);
            start_upd_q.push_back(mvp_update);
            start_x_q.push_back(mvp_x);
            start_y_q.push_back(mvp_y);
            start_z_q.push_back(mvp_z);
            if (!mvp_done) start_viol++;
        end
        if (out_valid) valid_cycles++;
        if (out_valid && out_ready) begin
            hs_cyc_q.push_back(cyc);
            hs_x_q.push_back(out_x);
            hs_y_q.push_back(out_y);
            hs_z_q.push_back(out_z);
            hs_idx_q.push_back(out_index);
            hs_last_q.push_back(out_last);
        end
        if (frame_done) done_cyc_q.push_back(cyc);
        if (overrun) ovr_cnt++;
        cyc++;
    end

    logic [31:0] exp_x [3] = '{32'h3F80_03E8, 32'h0000_03E8, 32'h0000_03E8};
    logic [31:0] exp_y [3] = '{32'h0000_07D0, 32'h3F80_07D0, 32'h0000_07D0};
    logic [31:0] exp_z [3] = '{32'hC0A0_0BB8, 32'hC0A0_0BB8, 32'hC0A0_0BB8};

    int total_checks = 0;
    int pass_checks  = 0;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) begin
            pass_checks++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic upd, input logic [ADDR_W:0] count);
        @(negedge clock);
        frame_start  = 1'b1;
        update_pose  = upd;
        num_vertices = count;
        @(negedge clock);
        frame_start  = 1'b0;
    endtask

    task automatic wait_frame_done(input int prev_done);
        int n = 0;
        while (done_cyc_q.size() == prev_done && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check_output("frame_done_timeout", 32'(done_cyc_q.size() > prev_done), 32'd1);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int ns, nh, nd, nf, nov, nv, sum, w;
        for (int i = 0; i < 16; i++) begin
            mem_x[i] = 32'(i); mem_y[i] = 32'(i * 2); mem_z[i] = 32'(i * 3);
        end
        mem_x[0] = 32'h3F80_0000; mem_y[0] = 32'h0;         mem_z[0] = 32'hC0A0_0000;
        mem_x[1] = 32'h0;         mem_y[1] = 32'h3F80_0000; mem_z[1] = 32'hC0A0_0000;
        mem_x[2] = 32'h0;         mem_y[2] = 32'h0;         mem_z[2] = 32'hC0A0_0000;

        $display("[TB] reset values");
        repeat (3) @(negedge clock);
        check_output("rst_busy", busy, 0);
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_frame_done", frame_done, 0);
        check_output("rst_mvp_start", mvp_start, 0);
        check_output("rst_mvp_update", mvp_update, 0);
        check_output("rst_vtx_addr", 32'(vtx_addr), 0);
        check_output("rst_out_x", out_x, 0);
        check_output("rst_out_last", out_last, 0);
        check_output("rst_mvp_roll", mvp_roll, 0);
        check_output("rst_mvp_x", mvp_x, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        $display("[TB] reset during XF_WAIT");
        nd = done_cyc_q.size();
        apply_stimulus(1'b0, 5'd2);
        repeat (4) @(negedge clock);
        check_output("xfwait_busy", busy, 1);
        check_output("xfwait_mvp_done_low", mvp_done, 0);
        reset = 1'b0;
        #1;
        check_output("abort_busy", busy, 0);
        check_output("abort_mvp_x", mvp_x, 0);
        check_output("abort_mvp_roll", mvp_roll, 0);
        check_output("abort_out_valid", out_valid, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        check_output("abort_no_done", done_cyc_q.size(), nd);

        $display("[TB] recovery frame, 2 vertices");
        nh = hs_cyc_q.size(); nd = done_cyc_q.size();
        apply_stimulus(1'b0, 5'd2);
        wait_frame_done(nd);
        check_output("rec_hs_count", hs_cyc_q.size() - nh, 2);
        check_output("rec_last0", hs_last_q[nh], 0);
        check_output("rec_idx1", 32'(hs_idx_q[nh+1]), 1);
        check_output("rec_last1", hs_last_q[nh+1], 1);
        check_output("rec_y1", hs_y_q[nh+1], 32'h3F80_07D0);

        $display("[TB] update pass + 3 vertices");
        ns = start_cyc_q.size(); nh = hs_cyc_q.size(); nd = done_cyc_q.size();
        apply_stimulus(1'b1, 5'd3);
        check_output("upd_mvp_roll", mvp_roll, ROLL_A);
        check_output("upd_mvp_yaw", mvp_yaw, YAW_A);
        wait_frame_done(nd);
        check_output("upd_start_count", start_cyc_q.size() - ns, 4);
        sum = 0;
        for (int k = ns; k < start_cyc_q.size(); k++) sum += int'(start_upd_q[k]);
        check_output("upd_pulse_count", sum, 1);
        check_output("upd_first_is_update", start_upd_q[ns], 1);
        check_output("upd_cam_x", start_x_q[ns], CAM_X_A);
        check_output("upd_cam_y", start_y_q[ns], CAM_Y_A);
        check_output("upd_cam_z", start_z_q[ns], CAM_Z_A);
        check_output("upd_hs_count", hs_cyc_q.size() - nh, 3);
        for (int k = 0; k < 3; k++) begin
            check_output("upd_idx", 32'(hs_idx_q[nh+k]), k);
            check_output("upd_last", hs_last_q[nh+k], 32'(k == 2));
            check_output("upd_x", hs_x_q[nh+k], exp_x[k]);
            check_output("upd_y", hs_y_q[nh+k], exp_y[k]);
            check_output("upd_z", hs_z_q[nh+k], exp_z[k]);
        end
        check_output("upd_done_lag", done_cyc_q[nd] - hs_cyc_q[nh+2], 1);

        $display("[TB] no update, 2 vertices");
        ns = start_cyc_q.size(); nf = fs_cyc_q.size(); nd = done_cyc_q.size();
        apply_stimulus(1'b0, 5'd2);
        wait_frame_done(nd);
        check_output("noupd_start_count", start_cyc_q.size() - ns, 2);
        check_output("noupd_no_update", start_upd_q[ns] | start_upd_q[ns+1], 0);
        check_output("noupd_start_lat", start_cyc_q[ns] - fs_cyc_q[nf], 3);

        $display("[TB] zero vertices with update");
        ns = start_cyc_q.size(); nh = hs_cyc_q.size(); nd = done_cyc_q.size(); nv = valid_cycles;
        apply_stimulus(1'b1, 5'd0);
        wait_frame_done(nd);
        check_output("zero_upd_starts", start_cyc_q.size() - ns, 1);
        check_output("zero_upd_is_update", start_upd_q[ns], 1);
        check_output("zero_upd_no_valid", valid_cycles - nv, 0);

        $display("[TB] zero vertices, no update");
        ns = start_cyc_q.size(); nf = fs_cyc_q.size(); nd = done_cyc_q.size();
        apply_stimulus(1'b0, 5'd0);
        wait_frame_done(nd);
        check_output("zero_done_lag", done_cyc_q[nd] - fs_cyc_q[nf], 1);
        check_output("zero_no_start", start_cyc_q.size() - ns, 0);

        $display("[TB] backpressure on vertex 0");
        nh = hs_cyc_q.size(); nd = done_cyc_q.size();
        out_ready = 1'b0;
        apply_stimulus(1'b0, 5'd2);
        w = 0;
        while (!out_valid && w < 300) begin
            @(negedge clock);
            w++;
        end
        check_output("bp_valid_timeout", out_valid, 1);
        ns = start_cyc_q.size();
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            check_output("bp_valid", out_valid, 1);
            check_output("bp_x", out_x, 32'h3F80_03E8);
            check_output("bp_z", out_z, 32'hC0A0_0BB8);
            check_output("bp_index", 32'(out_index), 0);
        end
        check_output("bp_no_new_start", start_cyc_q.size() - ns, 0);
        out_ready = 1'b1;
        wait_frame_done(nd);
        check_output("bp_hs_count", hs_cyc_q.size() - nh, 2);

        $display("[TB] frame_start while busy");
        ns = start_cyc_q.size(); nh = hs_cyc_q.size(); nd = done_cyc_q.size(); nov = ovr_cnt;
        apply_stimulus(1'b1, 5'd3);
        repeat (6) @(negedge clock);
        roll = 32'h9999_9999; cam_x = 32'h7777_7777; num_vertices = 5'd1; update_pose = 1'b0;
        frame_start = 1'b1;
        #1;
        check_output("ovr_pulse", overrun, 1);
        @(negedge clock);
        frame_start = 1'b0;
        #1;
        check_output("ovr_clear", overrun, 0);
        wait_frame_done(nd);
        check_output("ovr_count", ovr_cnt - nov, 1);
        check_output("ovr_hs_count", hs_cyc_q.size() - nh, 3);
        check_output("ovr_last_idx", 32'(hs_idx_q[nh+2]), 2);
        check_output("ovr_roll_kept", mvp_roll, ROLL_A);
        check_output("ovr_cam_kept", start_x_q[ns], CAM_X_A);
        roll = ROLL_A; cam_x = CAM_X_A;

        $display("[TB] mvp_done held low before XF_START");
        ns = start_cyc_q.size(); nf = fs_cyc_q.size(); nh = hs_cyc_q.size(); nd = done_cyc_q.size();
        apply_stimulus(1'b0, 5'd1);
        hold_done = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check_output("hold_busy", busy, 1);
        check_output("hold_no_start_a", mvp_start, 0);
        @(negedge clock);
        #1;
        check_output("hold_no_start_b", mvp_start, 0);
        @(negedge clock);
        hold_done = 1'b0;
        #1;
        check_output("hold_start", mvp_start, 1);
        wait_frame_done(nd);
        check_output("hold_start_lat", start_cyc_q[ns] - fs_cyc_q[nf], 5);
        check_output("hold_hs_x", hs_x_q[nh], 32'h3F80_03E8);
        check_output("hold_hs_last", hs_last_q[nh], 1);

        $display("[TB] maximum and clamped frame sizes");
        for (int t = 0; t < 2; t++) begin
            nh = hs_cyc_q.size(); nd = done_cyc_q.size();
            apply_stimulus(1'b0, (t == 0) ? 5'd16 : 5'd20);
            wait_frame_done(nd);
            check_output("max_hs_count", hs_cyc_q.size() - nh, 16);
            sum = 0;
            for (int k = nh; k < hs_last_q.size(); k++) sum += int'(hs_last_q[k]);
            check_output("max_last_count", sum, 1);
            check_output("max_final_idx", 32'(hs_idx_q[hs_idx_q.size()-1]), 15);
            check_output("max_final_last", hs_last_q[hs_last_q.size()-1], 1);
            check_output("max_final_x", hs_x_q[hs_x_q.size()-1], 32'd1015);
        end

        check_output("start_while_not_done", start_viol, 0);
        check_output("operand_stability", operand_viol, 0);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
